// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs RV32 R/I/S/U fields into words and writes them sequentially into IMEM
module instruction_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [6:0]        func7,
    input  logic [2:0]        func3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [19:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         enc;
    logic                xfer;

    assign full       = (count_q == DEPTH_C);
    assign in_ready   = (state_q == S_RUN) && !full && !finish;
    assign xfer       = in_valid && in_ready;
    assign done       = (state_q == S_DONE);
    assign count      = count_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    always_comb begin
        enc = 32'd0;
        case (fmt)
            2'd0:    enc = {func7, rs2, rs1, func3, rd, opcode};
            2'd1:    enc = {imm[11:0], rs1, func3, rd, opcode};
            2'd2:    enc = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            default: enc = {imm[19:0], rd, opcode};
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (start)       state_d = S_RUN;
                else if (finish) state_d = S_DONE;
            end
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        // start takes priority and swallows any transfer seen on the same edge
        if (start) begin
            count_d = '0;
            ptr_d   = '0;
        end else if (xfer) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc;
            count_d = count_q + 1'b1;
            ptr_d   = (ptr_q == LAST_C) ? ptr_q : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - scoreboard bench for instruction_encoder
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, finish, in_valid, in_ready;
    logic [1:0]  fmt;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [4:0]  rs1, rs2, rd;
    logic [19:0] imm;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;
    logic        full, done;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    instruction_encoder #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .func7(func7), .func3(func3), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [1:0] f, input logic [6:0] op, input logic [6:0] f7,
                              input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] d, input logic [19:0] im);
        fmt = f; opcode = op; func7 = f7; func3 = f3; rs1 = r1; rs2 = r2; rd = d; imm = im;
    endtask

    task automatic expect_write(input logic [5:0] a, input logic [31:0] w);
        wr_t e;
        e.addr = a;
        e.data = w;
        exp_q.push_back(e);
    endtask

    // Monitor: every IMEM write must match the oldest outstanding expectation
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && imem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", {26'd0, imem_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", {26'd0, imem_addr}, {26'd0, e.addr});
                    check("write_data", imem_wdata, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        set_fields(2'd0, 7'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 20'd0);
        #12;
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {26'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_count", {25'd0, count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        tick();

        start = 1'b1; tick(); start = 1'b0;
        check("run_ready", {31'd0, in_ready}, 32'd1);

        // One bundle of each format, back to back
        in_valid = 1'b1;
        set_fields(2'd0, 7'h33, 7'h20, 3'd0, 5'd2, 5'd3, 5'd1, 20'd0);
        expect_write(6'd0, 32'h403100B3); tick();
        set_fields(2'd1, 7'h13, 7'h7F, 3'd0, 5'd5, 5'd31, 5'd6, 20'hFFFFF);
        expect_write(6'd1, 32'hFFF28313); tick();
        set_fields(2'd2, 7'h23, 7'h7F, 3'd2, 5'd8, 5'd7, 5'd31, 20'hFF008);
        expect_write(6'd2, 32'h00742423); tick();
        set_fields(2'd3, 7'h37, 7'h7F, 3'd7, 5'd31, 5'd31, 5'd10, 20'h12345);
        expect_write(6'd3, 32'h12345537); tick();
        in_valid = 1'b0;
        check("count_after4", {25'd0, count}, 32'd4);

        // Restart with a bundle offered on the same edge: it must be dropped
        in_valid = 1'b1; start = 1'b1;
        set_fields(2'd3, 7'h37, 7'd0, 3'd0, 5'd0, 5'd0, 5'd1, 20'hABCDE);
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("count_after_start", {25'd0, count}, 32'd0);
        tick();

        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            set_fields(2'd3, 7'h37, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 20'(i));
            expect_write(6'(i), (32'(i) << 12) | 32'h37);
            tick();
        end
        check("count_full", {25'd0, count}, 32'd64);
        check("full_flag", {31'd0, full}, 32'd1);
        check("ready_when_full", {31'd0, in_ready}, 32'd0);
        set_fields(2'd3, 7'h37, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 20'h00040);
        tick();
        in_valid = 1'b0;
        check("count_after_65th", {25'd0, count}, 32'd64);
        tick();

        start = 1'b1; tick(); start = 1'b0;
        check("full_cleared", {31'd0, full}, 32'd0);
        in_valid = 1'b1;
        set_fields(2'd3, 7'h37, 7'd0, 3'd0, 5'd0, 5'd0, 5'd1, 20'hABCDE);
        expect_write(6'd0, 32'hABCDE0B7); tick();
        finish = 1'b1;
        set_fields(2'd0, 7'h33, 7'h20, 3'd0, 5'd2, 5'd3, 5'd1, 20'd0);
        tick();
        finish = 1'b0; in_valid = 1'b0;
        check("done_flag", {31'd0, done}, 32'd1);
        check("count_in_done", {25'd0, count}, 32'd1);
        check("ready_in_done", {31'd0, in_ready}, 32'd0);
        tick();

        start = 1'b1; tick(); start = 1'b0;
        check("count_restart", {25'd0, count}, 32'd0);
        check("done_cleared", {31'd0, done}, 32'd0);
        in_valid = 1'b1;
        set_fields(2'd2, 7'h23, 7'd0, 3'd2, 5'd8, 5'd7, 5'd0, 20'h00008);
        expect_write(6'd0, 32'h00742423); tick();
        in_valid = 1'b0;
        tick();

        // Reset while a write is presented
        in_valid = 1'b1;
        set_fields(2'd3, 7'h37, 7'd0, 3'd0, 5'd0, 5'd0, 5'd1, 20'hABCDE);
        tick();
        in_valid = 1'b0;
        check("we_before_reset", {31'd0, imem_we}, 32'd1);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("async_rst_we", {31'd0, imem_we}, 32'd0);
        check("async_rst_count", {25'd0, count}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
